// File: rtl/seq_divider_pkg.sv
// Shared definitions for the sequential arithmetic blocks.
// It holds the FSM state encoding and a counter-width helper.
package Divider_Defs;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } div_state_e;

  // Width of a down-counter that must hold the value n-1 (at least one bit)
  function automatic int cnt_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/seq_divider.sv
// Unsigned restoring divider that produces one quotient bit per clock, MSB first.
// A zero divisor skips the iteration and reports an all-ones quotient with a flag.
module seq_divider
  import Divider_Defs::*;
#(
  parameter int g_Width     = 12,
  parameter int g_Div_Width = 8
) (
  input  logic                   i_Clk,
  input  logic                   i_Rst,
  input  logic                   i_Start,
  input  logic [g_Width-1:0]     i_Dividend,
  input  logic [g_Div_Width-1:0] i_Divisor,
  output logic                   o_Ready,
  output logic                   o_Valid,
  output logic [g_Width-1:0]     o_Quotient,
  output logic [g_Div_Width-1:0] o_Remainder,
  output logic                   o_Div_By_Zero
);

  localparam int               CNT_W    = cnt_width(g_Width);
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(g_Width - 1);

  div_state_e             state;
  div_state_e             state_next;
  logic [CNT_W-1:0]       count;
  // Dividend bits leave at the top while quotient bits enter at the bottom
  logic [g_Width-1:0]     work;
  logic [g_Div_Width-1:0] divisor;
  logic [g_Div_Width:0]   partial;

  logic [g_Div_Width+1:0] trial;
  logic                   step_bit;
  logic [g_Div_Width:0]   step_partial;
  logic [g_Width-1:0]     step_work;
  logic                   divisor_zero;

  assign divisor_zero = (i_Divisor == '0);

  // One restoring step: a clear borrow bit of the trial subtraction means partial >= divisor
  always_comb begin
    trial        = {partial, work[g_Width-1]} - {2'b00, divisor};
    step_bit     = ~trial[g_Div_Width+1];
    step_partial = step_bit ? trial[g_Div_Width:0]
                            : {partial[g_Div_Width-1:0], work[g_Width-1]};
    step_work    = {work[g_Width-2:0], step_bit};
  end

  // NOTE: clocked state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge i_Clk) begin
    if (i_Rst) state <= ST_IDLE;
    else       state <= state_next;
  end

  // NOTE: the default assignment first keeps this combinational block from inferring a latch.
  always_comb begin
    state_next = state;
    unique case (state)
      ST_IDLE: if (i_Start) state_next = divisor_zero ? ST_DONE : ST_RUN;
      ST_RUN:  if (count == '0) state_next = ST_DONE;
      ST_DONE: state_next = ST_IDLE;
      default: state_next = ST_IDLE;
    endcase
  end

  always_comb begin
    o_Ready = (state == ST_IDLE);
    o_Valid = (state == ST_DONE);
  end

  always_ff @(posedge i_Clk) begin
    if (i_Rst) begin
      count         <= '0;
      work          <= '0;
      divisor       <= '0;
      partial       <= '0;
      o_Quotient    <= '0;
      o_Remainder   <= '0;
      o_Div_By_Zero <= 1'b0;
    end else begin
      unique case (state)
        ST_IDLE: begin
          if (i_Start) begin
            work    <= i_Dividend;
            divisor <= i_Divisor;
            partial <= '0;
            count   <= CNT_LOAD;
            if (divisor_zero) begin
              o_Quotient    <= '1;
              o_Remainder   <= i_Dividend[g_Div_Width-1:0];
              o_Div_By_Zero <= 1'b1;
            end
          end
        end
        ST_RUN: begin
          work    <= step_work;
          partial <= step_partial;
          if (count == '0) begin
            o_Quotient    <= step_work;
            o_Remainder   <= step_partial[g_Div_Width-1:0];
            o_Div_By_Zero <= 1'b0;
          end else begin
            count <= count - CNT_W'(1);
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_seq_divider.sv
// Directed and randomized checks of seq_divider at its default 12/8-bit configuration.
// Expected values come from integer division in the bench and from cycle counts.
module tb_seq_divider;

  localparam int W  = 12;
  localparam int DW = 8;

  logic          clk = 1'b0;
  logic          rst;
  logic          start;
  logic [W-1:0]  dividend;
  logic [DW-1:0] divisor;
  logic          ready;
  logic          valid;
  logic [W-1:0]  quotient;
  logic [DW-1:0] remainder;
  logic          dbz;

  int tests = 0;
  int fails = 0;

  seq_divider #(.g_Width(W), .g_Div_Width(DW)) dut (
    .i_Clk        (clk),
    .i_Rst        (rst),
    .i_Start      (start),
    .i_Dividend   (dividend),
    .i_Divisor    (divisor),
    .o_Ready      (ready),
    .o_Valid      (valid),
    .o_Quotient   (quotient),
    .o_Remainder  (remainder),
    .o_Div_By_Zero(dbz)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp)
    else begin
      fails++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Presents one request for a single cycle, then scrambles the inputs; returns at cycle 1 after acceptance
  task automatic launch(input logic [W-1:0] a, input logic [DW-1:0] b);
    @(negedge clk);
    check("ready_before_start", ready, 1);
    start    = 1'b1;
    dividend = a;
    divisor  = b;
    @(negedge clk);
    start    = 1'b0;
    dividend = W'($urandom);
    divisor  = DW'($urandom);
  endtask

  // Counts cycles after acceptance until the result strobe, bounded at 40
  task automatic wait_valid(input int lat0, output int lat, output int ready_highs);
    lat         = lat0;
    ready_highs = 0;
    while (valid !== 1'b1 && lat < 40) begin
      if (ready === 1'b1) ready_highs++;
      @(negedge clk);
      lat++;
    end
  endtask

  // The strobe lasts one cycle and the block is idle again with results held
  task automatic check_after(input string tag, input int q, input int r);
    @(negedge clk);
    check({tag, "_valid_drop"}, valid, 0);
    check({tag, "_ready_back"}, ready, 1);
    check({tag, "_q_hold"}, quotient, q);
    check({tag, "_r_hold"}, remainder, r);
  endtask

  task automatic directed(input string tag, input int a, input int b, input int lat_exp,
                          input int q, input int r, input int z);
    int lat, rh;
    launch(W'(a), DW'(b));
    wait_valid(1, lat, rh);
    check({tag, "_latency"}, lat, lat_exp);
    check({tag, "_ready_busy"}, rh, 0);
    check({tag, "_q"}, quotient, q);
    check({tag, "_r"}, remainder, r);
    check({tag, "_dbz"}, dbz, z);
    check_after(tag, q, r);
  endtask

  initial begin
    int lat, rh, rh2, seen;
    int pulses, last_pulse, cyc;
    logic [W-1:0]  a_q[$];
    logic [DW-1:0] b_q[$];
    logic [W-1:0]  a;
    logic [DW-1:0] b;

    rst = 1'b1; start = 1'b0; dividend = '0; divisor = '0;
    repeat (2) @(negedge clk);
    check("rst_ready", ready, 1);
    check("rst_valid", valid, 0);
    check("rst_q", quotient, 0);
    check("rst_r", remainder, 0);
    check("rst_dbz", dbz, 0);
    rst = 1'b0;
    @(negedge clk);
    check("post_rst_ready", ready, 1);

    directed("d2700", 2700, 180, 13, 15, 0, 0);
    directed("d1350", 1350, 180, 13, 7, 90, 0);
    directed("d4095", 4095, 180, 13, 22, 135, 0);
    directed("d0", 0, 180, 13, 0, 0, 0);
    directed("dz100", 100, 0, 1, 4095, 100, 1);
    directed("d255_1", 255, 1, 13, 255, 0, 0);

    // A second request in the middle of RUN must be dropped without queuing
    launch(W'(2700), DW'(180));
    rh = 0;
    for (int c = 1; c < 5; c++) begin
      if (ready === 1'b1) rh++;
      @(negedge clk);
    end
    check("ign_ready_c5", ready, 0);
    start = 1'b1; dividend = W'(900); divisor = DW'(180);
    @(negedge clk);
    check("ign_ready_c6", ready, 0);
    @(negedge clk);
    start = 1'b0;
    wait_valid(7, lat, rh2);
    check("ign_latency", lat, 13);
    check("ign_ready_busy", rh + rh2, 0);
    check("ign_q", quotient, 15);
    check("ign_r", remainder, 0);
    check_after("ign", 15, 0);
    seen = 0;
    repeat (20) begin
      @(negedge clk);
      if (valid === 1'b1) seen++;
    end
    check("ign_no_second", seen, 0);

    // Reset in the middle of RUN abandons the division
    launch(W'(1350), DW'(180));
    repeat (5) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check("midrst_ready", ready, 1);
    check("midrst_valid", valid, 0);
    check("midrst_q", quotient, 0);
    check("midrst_r", remainder, 0);
    check("midrst_dbz", dbz, 0);
    rst = 1'b0;
    seen = 0;
    repeat (20) begin
      @(negedge clk);
      if (valid === 1'b1) seen++;
    end
    check("midrst_no_valid", seen, 0);
    directed("d180", 180, 180, 13, 1, 0, 0);

    // Back-to-back divisions with start held high and fresh random operands every cycle
    pulses = 0; last_pulse = -1; cyc = 0;
    @(negedge clk);
    start = 1'b1;
    while (pulses < 1000 && cyc < 20000) begin
      if (valid === 1'b1) begin
        check("rand_pending", a_q.size() > 0, 1);
        if (a_q.size() > 0) begin
          a = a_q.pop_front();
          b = b_q.pop_front();
          check("rand_q", quotient, int'(a) / int'(b));
          check("rand_r", remainder, int'(a) % int'(b));
          check("rand_dbz", dbz, 0);
        end
        if (last_pulse >= 0) check("rand_spacing", cyc - last_pulse, 14);
        last_pulse = cyc;
        pulses++;
      end
      a = W'($urandom_range(0, (1 << W) - 1));
      b = DW'($urandom_range(1, (1 << DW) - 1));
      dividend = a;
      divisor  = b;
      if (ready === 1'b1) begin
        a_q.push_back(a);
        b_q.push_back(b);
      end
      @(negedge clk);
      cyc++;
    end
    start = 1'b0;
    check("rand_pulses", pulses, 1000);
    repeat (20) @(negedge clk);
    check("rand_idle", ready, 1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
